// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction and result handshake bundle for alu_issue_ctrl
//
// Purpose : groups the caller-facing handshake signals of alu_issue_ctrl.
// Signals : in_valid/in_ready/in_op/in_tag/in_a/in_b/in_c  instruction offer
//           res_valid/res_data/res_tag                      result pulse
// Modports: master = caller (testbench), slave = alu_issue_ctrl.
interface alu_issue_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [3:0]  in_tag;
   logic [29:0] in_a;
   logic [17:0] in_b;
   logic [47:0] in_c;
   logic        res_valid;
   logic [47:0] res_data;
   logic [3:0]  res_tag;

   modport master (
      output in_valid, in_op, in_tag, in_a, in_b, in_c,
      input  in_ready, res_valid, res_data, res_tag
   );

   modport slave (
      input  in_valid, in_op, in_tag, in_a, in_b, in_c,
      output in_ready, res_valid, res_data, res_tag
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue controller for a fixed-latency ALU with result reservation
//
// Purpose : decodes caller instructions into ALU control words, issues them one
//           cycle after acceptance, and returns each ALU result with its tag in
//           order of completion. A reservation shift register prevents two
//           results from landing on the same cycle.
// Ports   : clk, rst_n                          clock, async active-low reset
//           bus (slave)                         instruction offer / result pulse
//           a_o, b_o, c_o                       registered operands to ALU
//           alumode_o, inmode_o, opmode_o       registered ALU controls
//           usemult_o, cea2_o, ceb2_o           registered ALU controls
//           p_i                                 ALU result
//           err_op                              pulse on accepted illegal opcode
//           idle                                no operation in flight
// Timing  : an op accepted at edge I is on the ALU ports during cycle I; its
//           result is sampled from p_i at edge I+L and res_valid is high during
//           cycle I+L (L = LAT_MUL for multiplies, LAT_ALU otherwise).
//           Requires LAT_ALU < LAT_MUL <= 8.
module alu_issue_ctrl #(
   parameter int LAT_ALU = 4,
   parameter int LAT_MUL = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_issue_ctrl_if.slave  bus,
   output logic [29:0]      a_o,
   output logic [17:0]      b_o,
   output logic [47:0]      c_o,
   output logic [3:0]       alumode_o,
   output logic [4:0]       inmode_o,
   output logic [8:0]       opmode_o,
   output logic             usemult_o,
   output logic             cea2_o,
   output logic             ceb2_o,
   input  logic [47:0]      p_i,
   output logic             err_op,
   output logic             idle
);

   logic       dec_legal;
   logic [3:0] dec_alumode;
   logic [8:0] dec_opmode;
   logic       dec_usemult;

   always_comb begin
      dec_legal   = 1'b1;
      dec_alumode = 4'b0000;
      dec_opmode  = 9'h033;
      dec_usemult = 1'b0;
      case (bus.in_op)
         4'h0: ;
         4'h1: dec_alumode = 4'b0011;
         4'h2: begin
            dec_opmode  = 9'h005;
            dec_usemult = 1'b1;
         end
         4'h3: begin
            dec_opmode  = 9'h035;
            dec_usemult = 1'b1;
         end
         4'h4: dec_alumode = 4'b1100;
         4'h5: begin
            dec_alumode = 4'b1100;
            dec_opmode  = 9'h03B;
         end
         4'h6: dec_alumode = 4'b0100;
         default: dec_legal = 1'b0;
      endcase
   end

   // Slot k holds an op whose result is captured k+1 edges from now.
   logic [LAT_MUL-1:0] slot_v_q, slot_v_d;
   logic [3:0]         slot_tag_q [LAT_MUL];
   logic [3:0]         slot_tag_d [LAT_MUL];

   logic slot_busy;
   logic accept;
   logic issue;

   // A new op lands in slot L-1 after this edge, i.e. it collides with whatever
   // is now in slot L. Slot LAT_MUL does not exist, so multiplies never stall.
   assign slot_busy    = ~dec_usemult & slot_v_q[LAT_ALU];
   assign bus.in_ready = rst_n & (~dec_legal | ~slot_busy);
   assign accept       = bus.in_valid & bus.in_ready;
   assign issue        = accept & dec_legal;

   always_comb begin
      slot_v_d = slot_v_q >> 1;
      for (int k = 0; k < LAT_MUL - 1; k++) begin
         slot_tag_d[k] = slot_tag_q[k+1];
      end
      slot_tag_d[LAT_MUL-1] = slot_tag_q[LAT_MUL-1];
      if (issue) begin
         if (dec_usemult) begin
            slot_v_d[LAT_MUL-1]   = 1'b1;
            slot_tag_d[LAT_MUL-1] = bus.in_tag;
         end else begin
            slot_v_d[LAT_ALU-1]   = 1'b1;
            slot_tag_d[LAT_ALU-1] = bus.in_tag;
         end
      end
   end

   logic [29:0] a_q;
   logic [17:0] b_q;
   logic [47:0] c_q;
   logic [3:0]  alumode_q;
   logic [8:0]  opmode_q;
   logic        usemult_q;
   logic        ce_q;
   logic        err_q;
   logic        res_valid_q;
   logic [47:0] res_data_q;
   logic [3:0]  res_tag_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_v_q <= '0;
         for (int k = 0; k < LAT_MUL; k++) begin
            slot_tag_q[k] <= '0;
         end
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         alumode_q   <= '0;
         opmode_q    <= '0;
         usemult_q   <= 1'b0;
         ce_q        <= 1'b0;
         err_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_tag_q   <= '0;
      end else begin
         slot_v_q   <= slot_v_d;
         slot_tag_q <= slot_tag_d;
         ce_q       <= issue;
         err_q      <= accept & ~dec_legal;
         if (issue) begin
            a_q       <= bus.in_a;
            b_q       <= bus.in_b;
            c_q       <= bus.in_c;
            alumode_q <= dec_alumode;
            opmode_q  <= dec_opmode;
            usemult_q <= dec_usemult;
         end
         // Slot 0 is vacated by the shift on this same edge.
         res_valid_q <= slot_v_q[0];
         if (slot_v_q[0]) begin
            res_data_q <= p_i;
            res_tag_q  <= slot_tag_q[0];
         end
      end
   end

   assign a_o           = a_q;
   assign b_o           = b_q;
   assign c_o           = c_q;
   assign alumode_o     = alumode_q;
   assign inmode_o      = 5'h00;
   assign opmode_o      = opmode_q;
   assign usemult_o     = usemult_q;
   assign cea2_o        = ce_q;
   assign ceb2_o        = ce_q;
   assign err_op        = err_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_tag   = res_tag_q;
   assign idle          = ~|slot_v_q;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter LAT_ALU, default 4: cycles from issue to valid p_i for non-multiply ops.
REQ-002 Parameter LAT_MUL, default 5: cycles from issue to valid p_i for multiply ops; legal range LAT_ALU < LAT_MUL <= 8.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  instruction offered.
REQ-006 in_ready  out  1  instruction accepted when in_valid & in_ready.
REQ-007 in_op  in  4  opcode.
REQ-008 in_tag  in  4  caller tag, returned with the result.
REQ-009 in_a / in_b / in_c  in  30/18/48  operands.
REQ-010 a_o / b_o / c_o  out  30/18/48  operands to ALU, registered.
REQ-011 alumode_o / inmode_o / opmode_o  out  4/5/9  ALU controls, registered.
REQ-012 usemult_o, cea2_o, ceb2_o  out  1 each  ALU controls, registered.
REQ-013 p_i  in  48  ALU result.
REQ-014 res_valid  out  1  one-cycle pulse, res_data/res_tag valid.
REQ-015 res_data  out  48; res_tag  out  4.
REQ-016 err_op  out  1  one-cycle pulse on accepted illegal opcode.
REQ-017 idle  out  1  high when no operation is in flight.

Function
REQ-018 Decode (alumode, opmode, usemult): 0x0 ADD C+A:B (0000, 0x033, 0); 0x1 SUB C-A:B (0011, 0x033, 0); 0x2 MUL A*B (0000, 0x005, 1); 0x3 MAC C+A*B (0000, 0x035, 1); 0x4 AND (1100, 0x033, 0); 0x5 OR (1100, 0x03B, 0); 0x6 XOR (0100, 0x033, 0); inmode_o always 5'h00.
REQ-019 Opcodes 0x7-0xF are illegal: accepted, err_op pulses the cycle after acceptance, no issue, no reservation, no result.
REQ-020 Issue: an accepted legal op drives its operands and decoded controls on the next cycle, with cea2_o=ceb2_o=1 for exactly that cycle.
REQ-021 Non-issue cycles: cea2_o=ceb2_o=0; all other ALU outputs hold their last values.
REQ-022 Latency L = LAT_MUL if usemult else LAT_ALU, counted from the issue cycle.
REQ-023 Reservation shift register, LAT_MUL slots, each holding valid + tag; it shifts one slot per cycle.
REQ-024 in_ready = 0 when the candidate's result slot (L of its opcode) is already reserved; otherwise in_ready = 1.
REQ-025 in_ready for an illegal opcode is always 1.
REQ-026 in_ready is combinational from in_op and the reservation state.
REQ-027 When a slot reaches output, res_data is registered from p_i and res_tag from the slot, with res_valid=1 for one cycle.
REQ-028 Back-to-back issue of same-latency ops is allowed every cycle; peak throughput is 1 op/cycle.
REQ-029 An ALU op is stalled exactly when it would collide with a MUL issued LAT_MUL-LAT_ALU cycles earlier.
REQ-030 A slot is vacated in the same cycle its result is emitted.
REQ-031 idle = 1 when every reservation slot is empty and no issue is pending.

Reset
REQ-032 When rst_n=0, all outputs are 0 (in_ready=0, idle=1 excepted).
REQ-033 When rst_n=0, all reservations and pending results are dropped.
REQ-034 Reset mid-operation emits no res_valid for in-flight ops, including after rst_n rises.
REQ-035 in_ready may assert in the first cycle after rst_n deasserts.

Verification
REQ-036 ADD, in_a=0, in_b=5, in_c=10, tag 3 -> issue cycle alumode 0000, opmode 0x033, usemult 0, cea2=ceb2=1; res_valid 4 cycles later with res_tag 3 and res_data = p_i.
REQ-037 MUL tag 1 at t0, then ADD tag 2 offered at t1 -> in_ready=0 at t1 and the ADD is accepted at t2; results arrive in order, tag 1 then tag 2, on consecutive cycles.
REQ-038 Eight consecutive ADDs -> in_ready stays 1; eight res_valid pulses on consecutive cycles with tags in order.
REQ-039 in_op=0xA -> err_op pulses once, no cea2 pulse, idle stays 1, no res_valid.
REQ-040 Reset asserted with 3 ops in flight -> no res_valid afterwards, idle=1, cea2_o=0, opmode_o=0.
REQ-041 MAC, then 3 idle cycles -> controls hold their values, cea2_o=ceb2_o=0 after the issue cycle, res_valid at LAT_MUL.
